// File: rtl/mem_block_copier.sv
// Block copier for the 32 x 8 single-port data memory. Moves `length` bytes from
// src_addr to dst_addr using read-then-write cycles and sums the bytes it moves.
module mem_block_copier #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] src_ptr_q,  src_ptr_d;
  logic [ADDR_WIDTH-1:0] dst_ptr_q,  dst_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,    count_d;
  logic [DATA_WIDTH-1:0] data_q,     data_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      count_q    <= '0;
      data_q     <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      checksum_q <= checksum_d;
    end
  end

  // NOTE: every signal gets a hold default before the case; a branch that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    count_d    = count_q;
    data_d     = data_q;
    checksum_d = checksum_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          checksum_d = '0;
          if (length != '0) begin
            src_ptr_d = src_addr;
            dst_ptr_d = dst_addr;
            count_d   = length;
            state_d   = READ;
          end else begin
            state_d   = DONE;
          end
        end
      end
      READ: begin
        data_d     = mem_read_data;
        checksum_d = checksum_q + mem_read_data;
        state_d    = WRITE;
      end
      WRITE: begin
        // Pointers wrap silently at the top of the address space.
        src_ptr_d = src_ptr_q + ADDR_WIDTH'(1);
        dst_ptr_d = dst_ptr_q + ADDR_WIDTH'(1);
        count_d   = count_q - (ADDR_WIDTH+1)'(1);
        state_d   = (count_q == (ADDR_WIDTH+1)'(1)) ? DONE : READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory port is decoded from state alone, so reset drops the strobe at once.
  always_comb begin
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    unique case (state_q)
      READ: begin
        mem_address = src_ptr_q;
      end
      WRITE: begin
        mem_address      = dst_ptr_q;
        mem_write_enable = 1'b1;
        mem_write_data   = data_q;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q == READ) || (state_q == WRITE);
  assign done     = (state_q == DONE);
  assign checksum = checksum_q;

endmodule

// File: tb/tb_mem_block_copier.sv
// Directed bench for mem_block_copier with a negedge-write, combinational-read
// 32 x 8 memory model and hand-computed expected contents and timing.
module tb_mem_block_copier;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] src_addr;
  logic [4:0] dst_addr;
  logic [5:0] length;
  logic       busy;
  logic       done;
  logic [7:0] checksum;
  logic [4:0] mem_address;
  logic       mem_write_enable;
  logic [7:0] mem_write_data;
  logic [7:0] mem_read_data;

  logic [7:0] mem [32];
  logic [7:0] snap [32];
  logic       pl_en;
  logic [4:0] pl_addr;
  logic [7:0] pl_data;

  int n_cmp = 0;
  int n_err = 0;

  mem_block_copier #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .checksum         (checksum),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: bench preload port has priority over the DUT strobe.
  always @(negedge clk) begin
    if (pl_en)                 mem[pl_addr]     <= pl_data;
    else if (mem_write_enable) mem[mem_address] <= mem_write_data;
  end
  assign mem_read_data = mem[mem_address];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Runs one transfer from a point in the low phase. Cycle k is the k-th cycle
  // after the accepting edge; outputs are sampled at each negedge.
  task automatic run_copy(input logic [4:0] s, input logic [4:0] d, input logic [5:0] l,
                          input int inj, output int done_cyc, output int first_busy,
                          output int last_busy, output int busy_cnt, output int we_cnt);
    done_cyc = -1; first_busy = -1; last_busy = -1; busy_cnt = 0; we_cnt = 0;
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = k;
        last_busy = k;
      end
      if (mem_write_enable) we_cnt++;
      if (k == inj) begin
        start = 1'b1; src_addr = 5'd0; dst_addr = 5'd20; length = 6'd2;
      end
      if (done) begin
        done_cyc = k;
        start    = 1'b0;
        break;
      end
    end
    if (done_cyc < 0) check("timeout_waiting_done", 32'd0, 32'd1);
  endtask

  int dc, fb, lb, bc, wc, diffs;

  initial begin
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 32; i++) preload(5'(i), 8'h00);
    check("rst_busy",   32'(busy), 0);
    check("rst_done",   32'(done), 0);
    check("rst_we",     32'(mem_write_enable), 0);
    check("rst_cksum",  32'(checksum), 0);
    check("rst_addr",   32'(mem_address), 0);
    check("rst_wdata",  32'(mem_write_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic copy 25..29 -> 10..14
    preload(25, 8'd9); preload(26, 8'd7); preload(27, 8'd5); preload(28, 8'd3); preload(29, 8'd1);
    run_copy(25, 10, 5, 0, dc, fb, lb, bc, wc);
    check("t1_done_cycle", 32'(dc), 11);
    check("t1_busy_first", 32'(fb), 1);
    check("t1_busy_last",  32'(lb), 10);
    check("t1_busy_count", 32'(bc), 10);
    check("t1_we_count",   32'(wc), 5);
    check("t1_busy_at_done", 32'(busy), 0);
    check("t1_cksum",      32'(checksum), 32'h19);
    check("t1_m10", 32'(mem[10]), 9);
    check("t1_m11", 32'(mem[11]), 7);
    check("t1_m12", 32'(mem[12]), 5);
    check("t1_m13", 32'(mem[13]), 3);
    check("t1_m14", 32'(mem[14]), 1);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done), 0);
    repeat (3) @(negedge clk);
    check("t1_cksum_hold", 32'(checksum), 32'h19);

    // Wrap-around source 30,31,0,1 -> 16..19
    preload(0, 8'h99); preload(1, 8'h9A);
    run_copy(30, 16, 4, 0, dc, fb, lb, bc, wc);
    check("t2_done_cycle", 32'(dc), 9);
    check("t2_cksum", 32'(checksum), 32'h33);
    check("t2_m16", 32'(mem[16]), 8'h00);
    check("t2_m17", 32'(mem[17]), 8'h00);
    check("t2_m18", 32'(mem[18]), 8'h99);
    check("t2_m19", 32'(mem[19]), 8'h9A);
    @(negedge clk);

    // Zero length: done in cycle 1, nothing written, checksum cleared
    for (int i = 0; i < 32; i++) snap[i] = mem[i];
    run_copy(3, 7, 0, 0, dc, fb, lb, bc, wc);
    check("t3_done_cycle", 32'(dc), 1);
    check("t3_we_count", 32'(wc), 0);
    check("t3_busy_count", 32'(bc), 0);
    check("t3_cksum", 32'(checksum), 0);
    diffs = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== snap[i]) diffs++;
    check("t3_mem_unchanged", 32'(diffs), 0);
    @(negedge clk);

    // Start re-asserted with new operands from cycle 3 through DONE is ignored
    for (int i = 10; i < 15; i++) preload(5'(i), 8'hEE);
    preload(20, 8'hEE); preload(21, 8'hEE);
    run_copy(25, 10, 5, 3, dc, fb, lb, bc, wc);
    check("t4_done_cycle", 32'(dc), 11);
    check("t4_we_count", 32'(wc), 5);
    check("t4_cksum", 32'(checksum), 32'h19);
    @(negedge clk);
    check("t4_no_restart_busy", 32'(busy), 0);
    @(negedge clk);
    check("t4_no_restart_busy2", 32'(busy), 0);
    check("t4_m10", 32'(mem[10]), 9);
    check("t4_m14", 32'(mem[14]), 1);
    check("t4_m20", 32'(mem[20]), 8'hEE);
    check("t4_m21", 32'(mem[21]), 8'hEE);

    // Overlap dst = src + 1: source byte propagates forward
    run_copy(25, 26, 3, 0, dc, fb, lb, bc, wc);
    check("t5_cksum", 32'(checksum), 27);
    check("t5_m25", 32'(mem[25]), 9);
    check("t5_m26", 32'(mem[26]), 9);
    check("t5_m27", 32'(mem[27]), 9);
    check("t5_m28", 32'(mem[28]), 9);
    check("t5_m29", 32'(mem[29]), 1);
    @(negedge clk);

    // Reset during the high phase of the third WRITE cycle (cycle 6)
    preload(26, 8'd7); preload(27, 8'd5); preload(28, 8'd3);
    for (int i = 10; i < 15; i++) preload(5'(i), 8'hEE);
    src_addr = 25; dst_addr = 10; length = 5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("t6_in_write", 32'(mem_write_enable), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_we",    32'(mem_write_enable), 0);
    check("t6_rst_busy",  32'(busy), 0);
    check("t6_rst_addr",  32'(mem_address), 0);
    check("t6_rst_wdata", 32'(mem_write_data), 0);
    check("t6_rst_cksum", 32'(checksum), 0);
    check("t6_rst_done",  32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_m10", 32'(mem[10]), 9);
    check("t6_m11", 32'(mem[11]), 7);
    check("t6_m12", 32'(mem[12]), 8'hEE);
    check("t6_m13", 32'(mem[13]), 8'hEE);
    check("t6_m14", 32'(mem[14]), 8'hEE);
    run_copy(25, 10, 5, 0, dc, fb, lb, bc, wc);
    check("t6_rerun_done_cycle", 32'(dc), 11);
    check("t6_rerun_cksum", 32'(checksum), 32'h19);
    check("t6_rerun_m12", 32'(mem[12]), 5);
    check("t6_rerun_m14", 32'(mem[14]), 1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
